block_code_codec: RTL and testbench
===================================

BLOCK_CODE_CODEC -- requirements
Module: block_code_codec

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, SHALL be at least 2.
REQ-002 Parameter MODE, default 0: code mode; 0 = complement (check half = ~data), 1 = repetition (check half = data).
REQ-003 Parameter CNT_W, default 16: width of the error-word counter.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enc_in_valid  in  1  encoder input word valid.
REQ-007 enc_in_ready  out  1  encoder can accept input.
REQ-008 enc_in_data  in  DATA_W  payload to encode.
REQ-009 enc_out_valid  out  1  codeword valid.
REQ-010 enc_out_ready  in  1  downstream accepts codeword.
REQ-011 enc_out_data  out  2*DATA_W  codeword {payload, check}.
REQ-012 dec_in_valid  in  1  received codeword valid.
REQ-013 dec_in_ready  out  1  decoder can accept codeword.
REQ-014 dec_in_data  in  2*DATA_W  received codeword.
REQ-015 dec_out_valid  out  1  decoded word valid.
REQ-016 dec_out_ready  in  1  downstream accepts decoded word.
REQ-017 dec_out_data  out  DATA_W  decoded payload (upper half of codeword).
REQ-018 dec_out_err  out  1  check half mismatched for this word.
REQ-019 dec_out_err_bits  out  $clog2(DATA_W+1)  count of mismatched bit positions for this word.
REQ-020 err_cnt_clr  in  1  synchronous clear of err_cnt.
REQ-021 err_cnt  out  CNT_W  saturating count of errored words accepted by the decoder.

Function
REQ-022 A transfer on any port SHALL occur only in a cycle where valid and ready are both high.
REQ-023 Encoder and decoder SHALL each be one registered stage: latency exactly 1 cycle from input transfer to output valid; throughput one word per cycle.
REQ-024 Each stage's in_ready SHALL equal (!out_valid || out_ready), combinationally; no other path from out_ready to in_ready.
REQ-025 While out_valid is high and out_ready low, all output data/flag fields of that stage SHALL hold stable.
REQ-026 out_valid SHALL fall after an output transfer unless a new input transfer occurs in the same cycle, in which case the new word SHALL load.
REQ-027 Encoder: enc_out_data[2*DATA_W-1:DATA_W] = payload; lower half = ~payload (MODE 0) or payload (MODE 1).
REQ-028 Decoder: dec_out_data = dec_in_data upper half, uncorrected.
REQ-029 Decoder: mismatch vector = lower half XOR expected check half of the upper half; dec_out_err_bits = popcount(mismatch); dec_out_err = (err_bits != 0); all registered with the data.
REQ-030 err_cnt SHALL increment by 1 on each decoder input transfer whose mismatch is non-zero, independent of output backpressure.
REQ-031 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 err_cnt_clr SHALL set err_cnt to 0 next cycle; clear wins over a simultaneous increment.
REQ-033 Encoder and decoder paths SHALL be fully independent; simultaneous traffic on both SHALL not stall either.

Reset
REQ-034 On rst: enc_out_valid, dec_out_valid, dec_out_err, dec_out_err_bits, err_cnt = 0; enc_out_data, dec_out_data = 0.
REQ-035 rst mid-operation SHALL discard held words without output transfer; in_ready SHALL be 1 during and after reset.

Structure
REQ-036 Package block_code_pkg SHALL hold MODE constants (MODE_COMPLEMENT=0, MODE_REPETITION=1) and a check-half function shared by encoder and decoder.
REQ-037 One sub-module block_code_stage (parametrised-width valid/ready register slice) SHALL be instantiated for encoder and decoder outputs.

Verification (DATA_W=8 unless stated)
REQ-038 MODE 0, encode 0xA5 -> enc_out_data 0xA55A one cycle later; MODE 1 -> 0xA5A5.
REQ-039 MODE 0, decode 0x3CC3 -> data 0x3C, err 0, err_bits 0; decode 0x3CC2 -> data 0x3C, err 1, err_bits 1, err_cnt 1.
REQ-040 Backpressure: enc_out_ready low 3 cycles after 0x11 accepted -> enc_in_ready low, 0x1111-equivalent codeword 0x11EE held stable; release -> back-to-back stream resumes with no loss/duplication.
REQ-041 CNT_W=2: five errored words -> err_cnt 3; err_cnt_clr coincident with an errored word -> err_cnt 0.
REQ-042 rst asserted with both stages holding words -> both valids 0 next cycle, err_cnt 0, no output transfers observed.

Source files
------------

// File: rtl/block_code_pkg.sv
// block_code_pkg: code mode constants and the check-half bit function shared by encoder and decoder
package block_code_pkg;
  localparam int MODE_COMPLEMENT = 0;
  localparam int MODE_REPETITION = 1;
  function automatic logic check_bit(logic b, int mode);
    return (mode == MODE_COMPLEMENT) ? ~b : b;
  endfunction
endpackage

// File: rtl/block_code_stage.sv
// block_code_stage: single-entry valid/ready register slice with full throughput
module block_code_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  // load a new word whenever the slot is free or being drained this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end
endmodule

// File: rtl/block_code_codec.sv
// block_code_codec: complement/repetition block code encoder and checking decoder with error counter
module block_code_codec
  import block_code_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enc_in_valid,
  output logic                       enc_in_ready,
  input  logic [DATA_W-1:0]          enc_in_data,
  output logic                       enc_out_valid,
  input  logic                       enc_out_ready,
  output logic [2*DATA_W-1:0]        enc_out_data,
  input  logic                       dec_in_valid,
  output logic                       dec_in_ready,
  input  logic [2*DATA_W-1:0]        dec_in_data,
  output logic                       dec_out_valid,
  input  logic                       dec_out_ready,
  output logic [DATA_W-1:0]          dec_out_data,
  output logic                       dec_out_err,
  output logic [$clog2(DATA_W+1)-1:0] dec_out_err_bits,
  input  logic                       err_cnt_clr,
  output logic [CNT_W-1:0]           err_cnt
);
  localparam int EB_W = $clog2(DATA_W+1);
  logic [DATA_W-1:0]      enc_chk, dec_exp, mm;
  logic [EB_W-1:0]        bits;
  logic [DATA_W+EB_W:0]   dec_q;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  for (genvar g = 0; g < DATA_W; g++) begin : g_chk
    assign enc_chk[g] = check_bit(enc_in_data[g], MODE);
    assign dec_exp[g] = check_bit(dec_in_data[DATA_W+g], MODE);
  end
  assign mm = dec_in_data[DATA_W-1:0] ^ dec_exp;
  // popcount of the mismatch vector
  always_comb begin
    bits = '0;
    for (int i = 0; i < DATA_W; i++) bits = bits + EB_W'(mm[i]);
  end
  block_code_stage #(.W(2*DATA_W)) u_enc (
    .clk(clk), .rst(rst),
    .in_valid(enc_in_valid), .in_ready(enc_in_ready), .in_data({enc_in_data, enc_chk}),
    .out_valid(enc_out_valid), .out_ready(enc_out_ready), .out_data(enc_out_data)
  );
  block_code_stage #(.W(DATA_W+EB_W+1)) u_dec (
    .clk(clk), .rst(rst),
    .in_valid(dec_in_valid), .in_ready(dec_in_ready),
    .in_data({dec_in_data[2*DATA_W-1:DATA_W], bits != '0, bits}),
    .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(dec_q)
  );
  assign {dec_out_data, dec_out_err, dec_out_err_bits} = dec_q;
  assign err_cnt = err_cnt_q;
  // count errored words at decoder acceptance; clear beats increment, saturate at all-ones
  always_comb
    err_cnt_d = err_cnt_clr ? '0
              : (dec_in_valid && dec_in_ready && mm != '0 && err_cnt_q != '1) ? err_cnt_q + 1'b1
              : err_cnt_q;
  // error counter register
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end
endmodule

// File: tb/tb_block_code_codec.sv
// tb_block_code_codec: directed checks of encode, decode, backpressure, saturation and reset
module tb_block_code_codec;
  logic clk = 0, rst = 1;
  logic enc_in_valid = 0, enc_out_ready = 1, dec_in_valid = 0, dec_out_ready = 1, err_cnt_clr = 0;
  logic [7:0]  enc_in_data = 0;
  logic [15:0] dec_in_data = 0;
  logic        ei_r [3], eo_v [3], di_r [3], do_v [3], do_e [3];
  logic [15:0] eo_d [3];
  logic [7:0]  do_d [3];
  logic [3:0]  do_b [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  block_code_codec #(.DATA_W(8), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .enc_in_valid(enc_in_valid), .enc_in_ready(ei_r[0]), .enc_in_data(enc_in_data),
    .enc_out_valid(eo_v[0]), .enc_out_ready(enc_out_ready), .enc_out_data(eo_d[0]),
    .dec_in_valid(dec_in_valid), .dec_in_ready(di_r[0]), .dec_in_data(dec_in_data),
    .dec_out_valid(do_v[0]), .dec_out_ready(dec_out_ready), .dec_out_data(do_d[0]), .dec_out_err(do_e[0]),
    .dec_out_err_bits(do_b[0]), .err_cnt_clr(err_cnt_clr), .err_cnt(cnt0));
  block_code_codec #(.DATA_W(8), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .enc_in_valid(enc_in_valid), .enc_in_ready(ei_r[1]), .enc_in_data(enc_in_data),
    .enc_out_valid(eo_v[1]), .enc_out_ready(enc_out_ready), .enc_out_data(eo_d[1]),
    .dec_in_valid(dec_in_valid), .dec_in_ready(di_r[1]), .dec_in_data(dec_in_data),
    .dec_out_valid(do_v[1]), .dec_out_ready(dec_out_ready), .dec_out_data(do_d[1]), .dec_out_err(do_e[1]),
    .dec_out_err_bits(do_b[1]), .err_cnt_clr(err_cnt_clr), .err_cnt(cnt1));
  block_code_codec #(.DATA_W(8), .MODE(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .enc_in_valid(enc_in_valid), .enc_in_ready(ei_r[2]), .enc_in_data(enc_in_data),
    .enc_out_valid(eo_v[2]), .enc_out_ready(enc_out_ready), .enc_out_data(eo_d[2]),
    .dec_in_valid(dec_in_valid), .dec_in_ready(di_r[2]), .dec_in_data(dec_in_data),
    .dec_out_valid(do_v[2]), .dec_out_ready(dec_out_ready), .dec_out_data(do_d[2]), .dec_out_err(do_e[2]),
    .dec_out_err_bits(do_b[2]), .err_cnt_clr(err_cnt_clr), .err_cnt(cnt2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: wait expired after %0d checks", checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    tick;
    tick;
    chk("rst_enc_valid", eo_v[0], 1'b0);
    chk("rst_enc_data", eo_d[0], 16'h0000);
    chk("rst_dec_valid", do_v[0], 1'b0);
    chk("rst_dec_bits", do_b[0], 4'h0);
    chk("rst_err_cnt", cnt0, 16'h0000);
    chk("rst_enc_ready", ei_r[0], 1'b1);
    chk("rst_dec_ready", di_r[0], 1'b1);
    rst = 0;
    enc_in_valid = 1; enc_in_data = 8'hA5;
    tick;
    enc_in_valid = 0;
    chk("enc_a5_valid", eo_v[0], 1'b1);
    chk("enc_a5_m0", eo_d[0], 16'hA55A);
    chk("enc_a5_m1", eo_d[1], 16'hA5A5);
    tick;
    chk("enc_valid_drop", eo_v[0], 1'b0);
    dec_in_valid = 1; dec_in_data = 16'h3CC3;
    tick;
    chk("dec_ok_data", do_d[0], 8'h3C);
    chk("dec_ok_err", do_e[0], 1'b0);
    chk("dec_ok_bits", do_b[0], 4'h0);
    chk("dec_ok_cnt", cnt0, 16'h0000);
    chk("dec_m1_bits", do_b[1], 4'h8);
    dec_in_data = 16'h3CC2;
    tick;
    chk("dec_e1_data", do_d[0], 8'h3C);
    chk("dec_e1_err", do_e[0], 1'b1);
    chk("dec_e1_bits", do_b[0], 4'h1);
    chk("dec_e1_cnt", cnt0, 16'h0001);
    dec_in_data = 16'h3C00;
    tick;
    chk("dec_e4_bits", do_b[0], 4'h4);
    chk("dec_e4_cnt", cnt0, 16'h0002);
    dec_in_valid = 0; err_cnt_clr = 1;
    tick;
    err_cnt_clr = 0;
    chk("clr_cnt0", cnt0, 16'h0000);
    chk("clr_cnt2", cnt2, 2'd0);
    dec_in_valid = 1; dec_in_data = 16'h3CC2;
    for (int i = 0; i < 5; i++) tick;
    chk("sat_cnt2", cnt2, 2'd3);
    chk("five_cnt0", cnt0, 16'h0005);
    err_cnt_clr = 1;
    tick;
    chk("clr_win_cnt2", cnt2, 2'd0);
    chk("clr_win_cnt0", cnt0, 16'h0000);
    dec_in_valid = 0; err_cnt_clr = 0;
    tick;
    enc_in_valid = 1; enc_in_data = 8'h11;
    tick;
    chk("bp_load", eo_d[0], 16'h11EE);
    enc_out_ready = 0; enc_in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_ready", ei_r[0], 1'b0);
      chk("bp_valid", eo_v[0], 1'b1);
      chk("bp_hold", eo_d[0], 16'h11EE);
    end
    enc_out_ready = 1;
    #1;
    chk("bp_release_ready", ei_r[0], 1'b1);
    tick;
    chk("stream_22", eo_d[0], 16'h22DD);
    enc_in_data = 8'h33;
    tick;
    chk("stream_33", eo_d[0], 16'h33CC);
    enc_in_valid = 0;
    tick;
    chk("stream_end", eo_v[0], 1'b0);
    enc_out_ready = 0; dec_out_ready = 0;
    enc_in_valid = 1; enc_in_data = 8'h44;
    dec_in_valid = 1; dec_in_data = 16'h3CC2;
    tick;
    enc_in_valid = 0; dec_in_valid = 0;
    chk("hold_enc_valid", eo_v[0], 1'b1);
    chk("hold_dec_valid", do_v[0], 1'b1);
    chk("hold_dec_ready", di_r[0], 1'b0);
    tick;
    chk("hold_cnt_once", cnt0, 16'h0001);
    rst = 1;
    tick;
    chk("mid_rst_enc_valid", eo_v[0], 1'b0);
    chk("mid_rst_dec_valid", do_v[0], 1'b0);
    chk("mid_rst_cnt", cnt0, 16'h0000);
    chk("mid_rst_enc_ready", ei_r[0], 1'b1);
    chk("mid_rst_dec_data", do_d[0], 8'h00);
    rst = 0; enc_out_ready = 1; dec_out_ready = 1;
    tick;
    chk("post_rst_enc_valid", eo_v[0], 1'b0);
    chk("post_rst_dec_valid", do_v[0], 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
